// File: rtl/aes_ext_bus_if.sv
// Signal bundle between the AES core side, the block-command master and the external-bus bridge.
// Valid/ready channels (cmd, wr, rd): a beat transfers on a cycle where valid and ready are both 1;
// the valid side holds its payload stable until that cycle. bus_* uses held strobes closed by bus_acknowledge.
interface aes_ext_bus_if #(
    parameter int DATA_W    = 128,
    parameter int ADDR_W    = 6,
    parameter int MAX_BEATS = 4
);
    localparam int BE_W = DATA_W / 8;
    localparam int BW   = $clog2(MAX_BEATS + 1);

    logic              cmd_valid;
    logic              cmd_ready;
    logic              cmd_write;
    logic [ADDR_W-1:0] cmd_addr;
    logic [BW-1:0]     cmd_beats;
    logic [BE_W-1:0]   cmd_be;

    logic              wr_valid;
    logic              wr_ready;
    logic [DATA_W-1:0] wr_data;

    logic              rd_valid;
    logic              rd_ready;
    logic [DATA_W-1:0] rd_data;

    logic [ADDR_W-1:0] bus_address;
    logic [BE_W-1:0]   bus_byte_enable;
    logic              bus_read;
    logic              bus_write;
    logic [DATA_W-1:0] bus_write_data;
    logic              bus_acknowledge;
    logic [DATA_W-1:0] bus_read_data;

    modport master (
        input  cmd_valid, cmd_write, cmd_addr, cmd_beats, cmd_be,
        output cmd_ready,
        input  wr_valid, wr_data,
        output wr_ready,
        output rd_valid, rd_data,
        input  rd_ready,
        output bus_address, bus_byte_enable, bus_read, bus_write, bus_write_data,
        input  bus_acknowledge, bus_read_data
    );

    modport slave (
        output cmd_valid, cmd_write, cmd_addr, cmd_beats, cmd_be,
        input  cmd_ready,
        output wr_valid, wr_data,
        input  wr_ready,
        input  rd_valid, rd_data,
        output rd_ready,
        input  bus_address, bus_byte_enable, bus_read, bus_write, bus_write_data,
        output bus_acknowledge, bus_read_data
    );
endinterface

// File: rtl/aes_ext_bus_master.sv
// Splits multi-beat block commands into single-beat bridge transactions; read returns go to a FWFT FIFO.
// Define AES_BUS_ACK_TIMEOUT_EN to enable the ack-timeout watchdog and the sticky err flag.
module aes_ext_bus_master #(
    parameter int DATA_W    = 128,
    parameter int ADDR_W    = 6,
    parameter int MAX_BEATS = 4,
    parameter int TIMEOUT   = 255
) (
    input  logic                 clk,
    input  logic                 reset,
    aes_ext_bus_if.master        io,
    output logic                 busy,
    output logic                 done,
    output logic                 err,
    output logic [1:0]           state_dbg
);
    localparam int BW = $clog2(MAX_BEATS + 1);
    localparam int PW = (MAX_BEATS > 1) ? $clog2(MAX_BEATS) : 1;

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT_ACK, S_DONE} state_t;

    state_t            state;
    logic              write_q;
    logic [BW-1:0]     beats_left;
    logic [DATA_W-1:0] mem [MAX_BEATS];
    logic [PW-1:0]     wr_ptr;
    logic [PW-1:0]     rd_ptr;
    logic [BW-1:0]     count;
    logic              accept;
    logic              push;
    logic              pop;
    logic              ack_beat;
    logic              rd_credit;
    logic              timeout_hit;

    assign io.cmd_ready = (state == S_IDLE) && !reset;
    assign accept       = io.cmd_valid && io.cmd_ready;
    assign io.wr_ready  = (state == S_ISSUE) && write_q;
    assign io.rd_valid  = (count != '0);
    assign io.rd_data   = io.rd_valid ? mem[rd_ptr] : '0;
    assign pop          = io.rd_valid && io.rd_ready;
    assign ack_beat     = (state == S_WAIT_ACK) && io.bus_acknowledge;
    assign push         = ack_beat && !write_q;
    // A slot freed by this cycle's pop counts as credit for a new read beat.
    assign rd_credit    = (count < BW'(MAX_BEATS)) || pop;
    assign busy         = (state != S_IDLE);
    assign done         = (state == S_DONE);
    assign state_dbg    = state;

`ifdef AES_BUS_ACK_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT + 1);
    logic [TW-1:0] to_cnt;

    assign timeout_hit = (state == S_WAIT_ACK) && !io.bus_acknowledge && (to_cnt == TW'(TIMEOUT - 1));

    always_ff @(posedge clk) begin
        if (reset) begin
            to_cnt <= '0;
            err    <= 1'b0;
        end else begin
            if (accept)
                err <= 1'b0;
            else if (timeout_hit)
                err <= 1'b1;
            if (state != S_WAIT_ACK)
                to_cnt <= '0;
            else if (!io.bus_acknowledge)
                to_cnt <= to_cnt + 1'b1;
        end
    end
`else
    assign timeout_hit = 1'b0;
    assign err         = 1'b0 & (TIMEOUT != 0);
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state              <= S_IDLE;
            write_q            <= 1'b0;
            beats_left         <= '0;
            io.bus_address     <= '0;
            io.bus_byte_enable <= '0;
            io.bus_read        <= 1'b0;
            io.bus_write       <= 1'b0;
            io.bus_write_data  <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (accept) begin
                        write_q            <= io.cmd_write;
                        io.bus_address     <= io.cmd_addr;
                        io.bus_byte_enable <= io.cmd_be;
                        beats_left         <= (io.cmd_beats > BW'(MAX_BEATS)) ? BW'(MAX_BEATS) : io.cmd_beats;
                        state              <= (io.cmd_beats == '0) ? S_DONE : S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    if (write_q) begin
                        if (io.wr_valid) begin
                            io.bus_write_data <= io.wr_data;
                            io.bus_write      <= 1'b1;
                            state             <= S_WAIT_ACK;
                        end
                    end else if (rd_credit) begin
                        io.bus_read <= 1'b1;
                        state       <= S_WAIT_ACK;
                    end
                end
                S_WAIT_ACK: begin
                    if (io.bus_acknowledge) begin
                        io.bus_read    <= 1'b0;
                        io.bus_write   <= 1'b0;
                        io.bus_address <= io.bus_address + 1'b1;
                        beats_left     <= beats_left - 1'b1;
                        state          <= (beats_left == BW'(1)) ? S_DONE : S_ISSUE;
                    end else if (timeout_hit) begin
                        io.bus_read  <= 1'b0;
                        io.bus_write <= 1'b0;
                        beats_left   <= '0;
                        state        <= S_DONE;
                    end
                end
                S_DONE:  state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= io.bus_read_data;
                wr_ptr      <= (wr_ptr == PW'(MAX_BEATS - 1)) ? '0 : wr_ptr + 1'b1;
            end
            if (pop)
                rd_ptr <= (rd_ptr == PW'(MAX_BEATS - 1)) ? '0 : rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end
endmodule
